// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: CPU-domain clock-enable and reset controller.
//
// Runs entirely on clk_cpu_fast. After a synchronised PLL lock and a fixed
// stabilisation delay it releases the CPU reset. It then produces a
// divided clock enable that can be run, halted or single-stepped.
//
// Optional feature macro: CPU_CLOCK_CTRL_THROTTLE_EN
//   Defined   : run_mode 11 limits enables to frame_budget per video frame.
//               The frame is delimited by a synchronised vblank rising edge.
//   Undefined : run_mode 11 behaves as 00. frame_tick and budget_exhausted
//               are tied low, and the vblank path and budget counter are
//               not built.
//
// Step handshake: step_req is a level sampled only while the FSM is in
// HALT; sampling it high starts exactly one enable pulse. step_done is a
// one-cycle completion strobe in the cycle after that pulse, which is the
// same cycle the FSM is back in HALT. There is no back-pressure on either
// side. A request still held high at that point starts another step.
module cpu_clock_ctrl #(
  parameter int DIV_WIDTH    = 4,
  parameter int RESET_DELAY  = 128,
  parameter int SYNC_STAGES  = 3,
  parameter int BUDGET_WIDTH = 20
) (
  input  logic                    clk_cpu_fast,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [DIV_WIDTH-1:0]    div_sel,
  input  logic [1:0]              run_mode,
  input  logic                    step_req,
  input  logic                    vblank_async,
  input  logic [BUDGET_WIDTH-1:0] frame_budget,
  output logic                    clk_cpu_en,
  output logic                    rst_cpu_n,
  output logic [2:0]              state,
  output logic                    step_done,
  output logic                    frame_tick,
  output logic                    budget_exhausted
);

  typedef enum logic [2:0] {
    ST_LOCKWAIT = 3'b000,
    ST_STABLE   = 3'b001,
    ST_RUN      = 3'b010,
    ST_HALT     = 3'b011,
    ST_STEP     = 3'b100
  } state_t;

  localparam int DLY_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RESET_DELAY - 1);

  state_t                 state_q;
  state_t                 state_nxt;
  logic [DLY_W-1:0]       dly_cnt;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic                   mode_halt;
  logic [DIV_WIDTH-1:0]   n_q;
  logic [DIV_WIDTH-1:0]   n_m1;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic                   wrap;
  logic                   div_active;
  logic                   blocked;
  logic                   allowed;
  logic                   issue;
  logic                   cpu_active_nxt;

  assign state = state_q;

  // PLL lock synchroniser; lock_s is the last stage.
  always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s    = lock_sync[SYNC_STAGES-1];
  // Encodings 01 and 10 both mean halt; 00 and 11 both mean run.
  assign mode_halt = (run_mode == 2'b01) || (run_mode == 2'b10);

  // Next-state decode. Lock loss outranks every other transition.
  always_comb begin
    state_nxt = state_q;
    if (!lock_s) begin
      state_nxt = ST_LOCKWAIT;
    end else begin
      case (state_q)
        ST_LOCKWAIT: state_nxt = ST_STABLE;
        ST_STABLE: begin
          if (dly_cnt == DLY_LAST) begin
            state_nxt = mode_halt ? ST_HALT : ST_RUN;
          end
        end
        ST_RUN: begin
          if (mode_halt) begin
            state_nxt = ST_HALT;
          end
        end
        ST_HALT: begin
          if (!mode_halt) begin
            state_nxt = ST_RUN;
          end else if (step_req) begin
            state_nxt = ST_STEP;
          end
        end
        // Leave only once the single enable has been issued. Run-mode
        // changes wait until the FSM is back in HALT.
        ST_STEP: begin
          if (clk_cpu_en) begin
            state_nxt = ST_HALT;
          end
        end
        default: state_nxt = ST_LOCKWAIT;
      endcase
    end
  end

  // A latched ratio of 0 is treated as 1.
  assign n_m1 = (n_q == '0) ? '0 : (n_q - DIV_WIDTH'(1));
  // Treat any count at or above N-1 as a wrap. This covers the case where
  // the ratio shrinks below the current count on a div_cnt=0 latch, so the
  // counter can never run past the period end.
  assign wrap       = (div_cnt >= n_m1);
  assign div_active = (state_q == ST_RUN) || (state_q == ST_STEP);

  // Enable gating. In STEP only the first wrap is honoured: once the pulse
  // is out (clk_cpu_en high) the FSM is leaving STEP.
  assign allowed = lock_s &&
                   (((state_q == ST_RUN) && !blocked) ||
                    ((state_q == ST_STEP) && !clk_cpu_en));
  assign issue   = wrap && allowed;

  assign cpu_active_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_HALT) ||
                          (state_nxt == ST_STEP);

  // Divider. The ratio is latched only at a period boundary or while idle,
  // and the counter restarts from 0 whenever RUN or STEP is entered.
  always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      div_cnt <= '0;
    end else begin
      if (wrap || (div_cnt == '0)) begin
        n_q <= div_sel;
      end
      if (div_active && (state_nxt == state_q)) begin
        div_cnt <= wrap ? '0 : (div_cnt + DIV_WIDTH'(1));
      end else begin
        div_cnt <= '0;
      end
    end
  end

  // Control FSM with registered reset, enable and step-done outputs.
  always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOCKWAIT;
      dly_cnt    <= '0;
      rst_cpu_n  <= 1'b0;
      clk_cpu_en <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      dly_cnt    <= ((state_q == ST_STABLE) && (state_nxt == ST_STABLE)) ?
                    (dly_cnt + DLY_W'(1)) : '0;
      rst_cpu_n  <= cpu_active_nxt;
      clk_cpu_en <= issue;
      step_done  <= (state_q == ST_STEP) && (state_nxt == ST_HALT);
    end
  end

`ifdef CPU_CLOCK_CTRL_THROTTLE_EN
  logic [SYNC_STAGES-1:0]  vb_sync;
  logic                    vb_s;
  logic                    vb_d;
  logic                    frame_tick_q;
  logic                    budget_exh_q;
  logic                    throttled;
  logic [BUDGET_WIDTH-1:0] budget_cnt;
  logic [BUDGET_WIDTH-1:0] budget_nxt;

  assign vb_s      = vb_sync[SYNC_STAGES-1];
  assign throttled = (run_mode == 2'b11) && (frame_budget != '0);
  assign blocked   = throttled && (budget_cnt == '0);

  // Budget update. A frame tick reloads the budget; if an enable is issued
  // on the same edge, that enable is charged to the new frame.
  always_comb begin
    budget_nxt = budget_cnt;
    if (frame_tick_q) begin
      budget_nxt = (issue && (frame_budget != '0)) ?
                   (frame_budget - BUDGET_WIDTH'(1)) : frame_budget;
    end else if (issue && (budget_cnt != '0)) begin
      budget_nxt = budget_cnt - BUDGET_WIDTH'(1);
    end
  end

  // vblank synchroniser, rising-edge detect and frame budget counter.
  always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
    if (!rst_n) begin
      vb_sync      <= '0;
      vb_d         <= 1'b0;
      frame_tick_q <= 1'b0;
      budget_cnt   <= '0;
      budget_exh_q <= 1'b0;
    end else begin
      vb_sync      <= {vb_sync[SYNC_STAGES-2:0], vblank_async};
      vb_d         <= vb_s;
      frame_tick_q <= vb_s && !vb_d;
      budget_cnt   <= budget_nxt;
      // Rises on the edge the first enable is suppressed, falls on the edge
      // enables resume.
      budget_exh_q <= blocked;
    end
  end

  assign frame_tick       = frame_tick_q;
  assign budget_exhausted = budget_exh_q;
`else
  logic unused_throttle_inputs;

  assign unused_throttle_inputs = ^{vblank_async, frame_budget};
  assign blocked                = 1'b0;
  assign frame_tick             = 1'b0;
  assign budget_exhausted       = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed bench for cpu_clock_ctrl at default
// parameters. Divider and mode checks are table driven. Lock, step, halt,
// throttle and reset corner cases are hand-written sequences.
module tb_cpu_clock_ctrl;

  localparam int DW = 4;
  localparam int BW = 20;

  localparam logic [2:0] S_LOCKWAIT = 3'b000;
  localparam logic [2:0] S_STABLE   = 3'b001;
  localparam logic [2:0] S_RUN      = 3'b010;
  localparam logic [2:0] S_HALT     = 3'b011;
  localparam logic [2:0] S_STEP     = 3'b100;

  logic          clk_cpu_fast = 1'b0;
  logic          rst_n;
  logic          pll_locked;
  logic [DW-1:0] div_sel;
  logic [1:0]    run_mode;
  logic          step_req;
  logic          vblank_async;
  logic [BW-1:0] frame_budget;
  logic          clk_cpu_en;
  logic          rst_cpu_n;
  logic [2:0]    state;
  logic          step_done;
  logic          frame_tick;
  logic          budget_exhausted;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [DW-1:0] div;
    logic [1:0]    mode;
    logic [2:0]    exp_state;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[9];

  cpu_clock_ctrl dut (
    .clk_cpu_fast     (clk_cpu_fast),
    .rst_n            (rst_n),
    .pll_locked       (pll_locked),
    .div_sel          (div_sel),
    .run_mode         (run_mode),
    .step_req         (step_req),
    .vblank_async     (vblank_async),
    .frame_budget     (frame_budget),
    .clk_cpu_en       (clk_cpu_en),
    .rst_cpu_n        (rst_cpu_n),
    .state            (state),
    .step_done        (step_done),
    .frame_tick       (frame_tick),
    .budget_exhausted (budget_exhausted)
  );

  // Clock and watchdog
  always #5 clk_cpu_fast = ~clk_cpu_fast;

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // Driver and checking tasks
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_cpu_fast);
    #1;
  endtask

  task automatic count_en(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick();
      c += int'(clk_cpu_en);
    end
  endtask

  task automatic wait_rst_rise(output int edges, output int stable_edge);
    edges = 0;
    stable_edge = 0;
    while (!rst_cpu_n && edges < 400) begin
      tick();
      edges++;
      if (stable_edge == 0 && state == S_STABLE) stable_edge = edges;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (state != s && edges < bound);
  endtask

  // Count edges from an enable pulse to the next one, optionally
  // changing div_sel after change_at edges.
  task automatic gap(input int change_at, input logic [DW-1:0] nd, output int g);
    g = 0;
    do begin
      tick();
      g++;
      if (g == change_at) div_sel = nd;
    end while (!clk_cpu_en && g < 40);
  endtask

`ifdef CPU_CLOCK_CTRL_THROTTLE_EN
  task automatic wait_tick(input int bound, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!frame_tick && edges < bound);
  endtask
`endif

  // Main stimulus
  initial begin
    int e, se, c, c2, dbl, prev, g;

    vecs[0] = '{4'd1,  2'b00, S_RUN,  60};
    vecs[1] = '{4'd0,  2'b00, S_RUN,  60};
    vecs[2] = '{4'd2,  2'b00, S_RUN,  30};
    vecs[3] = '{4'd5,  2'b00, S_RUN,  12};
    vecs[4] = '{4'd15, 2'b00, S_RUN,  4};
    vecs[5] = '{4'd4,  2'b01, S_HALT, 0};
    vecs[6] = '{4'd4,  2'b10, S_HALT, 0};
    vecs[7] = '{4'd3,  2'b11, S_RUN,  20};
    vecs[8] = '{4'd6,  2'b00, S_RUN,  10};

    rst_n        = 1'b1;
    pll_locked   = 1'b0;
    div_sel      = 4'd1;
    run_mode     = 2'b00;
    step_req     = 1'b0;
    vblank_async = 1'b0;
    frame_budget = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("reset_clk_cpu_en", int'(clk_cpu_en), 0);
    check("reset_rst_cpu_n", int'(rst_cpu_n), 0);
    check("reset_state", int'(state), int'(S_LOCKWAIT));
    check("reset_step_done", int'(step_done), 0);
    check("reset_frame_tick", int'(frame_tick), 0);
    check("reset_budget_exhausted", int'(budget_exhausted), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Lock with N=1: STABLE after 4 edges, release after 4+128 edges
    pll_locked = 1'b1;
    wait_rst_rise(e, se);
    check("lock_to_stable_edges", se, 4);
    check("lock_to_release_edges", e, 132);
    check("release_state_run", int'(state), int'(S_RUN));
    check("release_edge_en_low", int'(clk_cpu_en), 0);
    tick();
    check("first_en_at_e_plus_1", int'(clk_cpu_en), 1);
    count_en(10, c);
    check("n1_continuous_en", c, 10);

    // Divider / mode table
    for (int i = 0; i < 9; i++) begin
      div_sel  = vecs[i].div;
      run_mode = vecs[i].mode;
      repeat (20) tick();
      check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_state));
      check($sformatf("vec%0d_rst_cpu_n", i), int'(rst_cpu_n), 1);
      c = 0;
      dbl = 0;
      prev = int'(clk_cpu_en);
      repeat (60) begin
        tick();
        c += int'(clk_cpu_en);
        if (clk_cpu_en && prev == 1) dbl++;
        prev = int'(clk_cpu_en);
      end
      check($sformatf("vec%0d_en_count", i), c, vecs[i].exp_cnt);
      check($sformatf("vec%0d_back_to_back", i), dbl, (vecs[i].exp_cnt == 60) ? 60 : 0);
    end

    // Ratio change 5 -> 3 mid-period: one 5-cycle period, then 3
    div_sel  = 4'd5;
    run_mode = 2'b00;
    repeat (20) tick();
    g = 0;
    while (!clk_cpu_en && g < 20) begin
      tick();
      g++;
    end
    check("midchg_found_pulse", int'(clk_cpu_en), 1);
    gap(2, 4'd3, g);
    check("midchg_gap_old", g, 5);
    gap(-1, 4'd3, g);
    check("midchg_gap_new1", g, 3);
    gap(-1, 4'd3, g);
    check("midchg_gap_new2", g, 3);

    // Single step with N=4
    div_sel  = 4'd4;
    run_mode = 2'b01;
    repeat (10) tick();
    check("halt_state", int'(state), int'(S_HALT));
    count_en(10, c);
    check("halt_no_en", c, 0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("step_entry_state", int'(state), int'(S_STEP));
    g = 0;
    do begin
      tick();
      g++;
    end while (!clk_cpu_en && g < 20);
    check("step_en_latency", g, 4);
    tick();
    check("step_done_pulse", int'(step_done), 1);
    check("step_back_halt", int'(state), int'(S_HALT));
    check("step_en_single", int'(clk_cpu_en), 0);
    tick();
    check("step_done_one_cycle", int'(step_done), 0);
    count_en(10, c);
    check("step_no_more_en", c, 0);

    // Single step with N=1 still gives exactly one enable
    div_sel = 4'd1;
    repeat (2) tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    c = 0;
    c2 = 0;
    repeat (5) begin
      tick();
      c += int'(clk_cpu_en);
      c2 += int'(step_done);
    end
    check("step_n1_en_count", c, 1);
    check("step_n1_done_count", c2, 1);
    check("step_n1_state", int'(state), int'(S_HALT));

    // Run request during STEP waits for the return to HALT
    div_sel = 4'd4;
    repeat (2) tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    run_mode = 2'b00;
    repeat (3) tick();
    check("step_ignores_run", int'(state), int'(S_STEP));
    tick();
    check("step_run_en", int'(clk_cpu_en), 1);
    tick();
    check("step_run_halt_first", int'(state), int'(S_HALT));
    check("step_run_done", int'(step_done), 1);
    tick();
    check("step_run_then_run", int'(state), int'(S_RUN));

    // step_req in RUN has no effect
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("step_in_run_state", int'(state), int'(S_RUN));
    tick();
    check("step_in_run_no_done", int'(step_done), 0);

    // Halt latency with N=1
    div_sel = 4'd1;
    repeat (5) tick();
    run_mode = 2'b01;
    tick();
    check("halt_latency_state", int'(state), int'(S_HALT));
    tick();
    check("halt_latency_en", int'(clk_cpu_en), 0);
    count_en(10, c);
    check("halt_latency_no_en", c, 0);

`ifdef CPU_CLOCK_CTRL_THROTTLE_EN
    // Throttled run: budget starts empty, so enables wait for a frame
    run_mode     = 2'b11;
    frame_budget = BW'(10);
    repeat (5) tick();
    check("thr_initial_blocked_en", int'(clk_cpu_en), 0);
    check("thr_initial_exhausted", int'(budget_exhausted), 1);
    // Frame A: clean reload gives 10 enables
    vblank_async = 1'b1;
    wait_tick(12, e);
    check("thr_vblank_to_tick", e, 4);
    vblank_async = 1'b0;
    tick();
    check("thr_a_tick_edge_en", int'(clk_cpu_en), 0);
    count_en(29, c);
    check("thr_a_en_count", c, 10);
    check("thr_a_exhausted", int'(budget_exhausted), 1);
    check("thr_a_en_suppressed", int'(clk_cpu_en), 0);
    // Frame B: second tick lands while enables flow
    vblank_async = 1'b1;
    wait_tick(12, e);
    vblank_async = 1'b0;
    tick();
    vblank_async = 1'b1;
    wait_tick(12, e);
    check("thr_b_tick_latency", e, 4);
    check("thr_b_not_exhausted", int'(budget_exhausted), 0);
    tick();
    check("thr_b_coincident_en", int'(clk_cpu_en), 1);
    count_en(29, c);
    check("thr_b_further_en", c, 9);
    check("thr_b_exhausted", int'(budget_exhausted), 1);
    vblank_async = 1'b0;
    // Mode 00 ignores the budget
    run_mode = 2'b00;
    repeat (3) tick();
    count_en(20, c);
    check("thr_mode00_en_count", c, 20);
    check("thr_mode00_not_exhausted", int'(budget_exhausted), 0);
`else
    // Without throttling, mode 11 is plain run and frame outputs stay low
    run_mode     = 2'b11;
    frame_budget = BW'(10);
    repeat (3) tick();
    c = 0;
    c2 = 0;
    dbl = 0;
    vblank_async = 1'b1;
    repeat (20) begin
      tick();
      c += int'(clk_cpu_en);
      c2 += int'(frame_tick);
      dbl += int'(budget_exhausted);
    end
    vblank_async = 1'b0;
    repeat (20) begin
      tick();
      c += int'(clk_cpu_en);
      c2 += int'(frame_tick);
      dbl += int'(budget_exhausted);
    end
    check("nothr_mode11_en_count", c, 40);
    check("nothr_frame_tick_low", c2, 0);
    check("nothr_exhausted_low", dbl, 0);
    run_mode = 2'b00;
    repeat (3) tick();
`endif

    // Lock loss while running, then relock
    pll_locked = 1'b0;
    wait_state(S_LOCKWAIT, 10, e);
    check("lockloss_edges", e, 4);
    check("lockloss_rst_cpu_n", int'(rst_cpu_n), 0);
    check("lockloss_en", int'(clk_cpu_en), 0);
    repeat (5) tick();
    pll_locked = 1'b1;
    wait_rst_rise(e, se);
    check("relock_to_release_edges", e, 132);
    check("relock_state", int'(state), int'(S_RUN));

    // Asynchronous reset in the middle of a step
    div_sel  = 4'd8;
    run_mode = 2'b01;
    repeat (3) tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("rststep_in_step", int'(state), int'(S_STEP));
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("rststep_state", int'(state), int'(S_LOCKWAIT));
    check("rststep_rst_cpu_n", int'(rst_cpu_n), 0);
    check("rststep_en", int'(clk_cpu_en), 0);
    check("rststep_done", int'(step_done), 0);
    check("rststep_frame_tick", int'(frame_tick), 0);
    check("rststep_exhausted", int'(budget_exhausted), 0);
    c = 0;
    repeat (5) begin
      tick();
      c += int'(step_done);
    end
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      c += int'(step_done);
    end
    check("rststep_no_done_after", c, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
